debug_unit_receive: RTL
=======================

// Module: debug_unit_receive
// PURPOSE
//  Command side of the MIPS debug unit. Decodes host bytes from the UART receiver.
//  Loads program words into instruction memory and starts continuous or step execution.
//  Issues single steps and paces them against the debug transmitter's dump (i_tx_done).
// PARAMETERS
//  NB_DATA         32    instruction word width
//  NB_BYTE         8     UART byte width
//  NB_ADDR         10    instruction memory byte-address width
//  TIMEOUT_CYCLES  1e6   inter-byte load timeout, used only with DU_RX_TIMEOUT_EN
// PORTS
//  i_clock               in   1        system clock
//  i_reset               in   1        synchronous, active-high reset
//  i_uart_rx_data        in   NB_BYTE  received byte, valid while i_uart_rx_done=1
//  i_uart_rx_done        in   1        1-cycle pulse, one byte received
//  i_halt                in   1        CPU reached HALT (level)
//  i_tx_done             in   1        1-cycle pulse, debug transmitter finished its dump
//  o_instruction_data    out  NB_DATA  word to write into instruction memory
//  o_instruction_address out  NB_ADDR  byte address of that word (multiple of 4)
//  o_instruction_write   out  1        1-cycle write strobe
//  o_execution_mode      out  1        0 = continuous, 1 = step
//  o_start               out  1        1-cycle pulse, CPU leaves reset/stall and starts
//  o_step                out  1        1-cycle pulse, advance CPU one cycle
//  o_program_loaded      out  1        level, at least one complete load finished
//  o_error               out  1        1-cycle pulse, command rejected or load aborted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, address/counters 0. Reset mid-load discards partial data.
//  Command bytes (accepted only in IDLE, otherwise ignored):
//   'L'=8'h4C load; 'C'=8'h43 run continuous; 'S'=8'h53 run step. Unknown byte -> o_error.
//  Load FSM:
//   IDLE --'L'--> LOAD_COUNT.
//   Next byte N = word count. N=0 -> IDLE, no writes, o_program_loaded unchanged.
//   LOAD_BYTES: 4*N bytes, MSB first, shifted into o_instruction_data.
//   Cycle after the 4th byte of a word: o_instruction_write=1 for 1 cycle. Address starts at 0
//   and advances by 4 per write, wrapping modulo 2^NB_ADDR.
//   After word N is written: o_program_loaded=1, state IDLE.
//   A byte arriving in the same cycle as the write strobe is still captured.
//  Run:
//   'C' or 'S' with o_program_loaded=0 -> o_error, stay IDLE.
//   'C' -> o_execution_mode=0, o_start pulse, state RUN_CONT.
//    RUN_CONT: rx bytes ignored. i_halt=1 -> WAIT_DUMP. i_tx_done in WAIT_DUMP -> IDLE.
//   'S' -> o_execution_mode=1, o_start pulse, state RUN_STEP.
//    RUN_STEP: 'N'=8'h4E -> o_step pulse next cycle, state WAIT_TX. Other bytes ignored.
//    WAIT_TX: rx bytes ignored (no step queueing). On i_tx_done: i_halt=1 -> IDLE, else RUN_STEP.
//  o_execution_mode holds its value through IDLE until the next run command.
//  o_start, o_step and o_instruction_write are never high in the same cycle.
//  Simultaneous i_halt and 'N' in RUN_STEP: halt wins, state WAIT_DUMP, no step.
// CONFIGURATION
//  DU_RX_TIMEOUT_EN defined:
//   - Counter reloads on every byte while in LOAD_COUNT/LOAD_BYTES.
//   - TIMEOUT_CYCLES with no byte -> o_error pulse, state IDLE.
//   - Address reset to 0; o_program_loaded unchanged.
//  DU_RX_TIMEOUT_EN undefined: no counter; a load waits forever for bytes.
// TESTING
//  Load: 'L', 8'h02, AA BB CC DD 11 22 33 44 -> writes 32'hAABBCCDD @0 and 32'h11223344 @4
//   -> o_program_loaded=1.
//  'C' before any load -> o_error pulse, o_start stays 0. 'Q' (8'h51) in IDLE -> o_error.
//  Load, 'S', 'N' -> o_start, then o_step pulse. Second 'N' before i_tx_done -> no o_step.
//   After i_tx_done, 'N' -> o_step.
//  Load, 'C', raise i_halt, pulse i_tx_done -> IDLE. A new 'L' is accepted.
//  i_reset after 'L', 8'h01, AA BB -> outputs 0, no write. Fresh full load writes @0.
//  With DU_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100: 'L', 8'h01, AA, then silence -> o_error at
//   cycle 100, state IDLE.

Source files
------------

// File: rtl/debug_unit_receive.sv
// debug_unit_receive: command side of the MIPS debug unit.
// Decodes host bytes from the UART receiver, loads program words into
// instruction memory, starts continuous or step execution and paces single
// steps against the debug transmitter's dump.
// Optional build macro: DU_RX_TIMEOUT_EN enables an inter-byte timeout that
// aborts a stalled load after TIMEOUT_CYCLES cycles without a byte.
module debug_unit_receive #(
    parameter int NB_DATA        = 32,
    parameter int NB_BYTE        = 8,
    parameter int NB_ADDR        = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_uart_rx_data,
    input  logic               i_uart_rx_done,
    input  logic               i_halt,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_instruction_data,
    output logic [NB_ADDR-1:0] o_instruction_address,
    output logic               o_instruction_write,
    output logic               o_execution_mode,
    output logic               o_start,
    output logic               o_step,
    output logic               o_program_loaded,
    output logic               o_error
);

    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
    localparam int NB_IDX         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_CONT = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_NEXT = NB_BYTE'(8'h4E);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COUNT,
        LOAD_BYTES,
        RUN_CONT,
        RUN_STEP,
        WAIT_TX,
        WAIT_DUMP
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [NB_BYTE-1:0]  word_total;
    logic [NB_BYTE-1:0]  word_done;
    logic [NB_IDX-1:0]   byte_idx;

    logic                load_begin;
    logic                count_take;
    logic                byte_take;
    logic                last_write;
    logic                load_abort;
    logic                start_nxt;
    logic                step_nxt;
    logic                error_nxt;
    logic                mode_nxt;
    logic                timeout_hit;

    wire in_load = (state == LOAD_COUNT) || (state == LOAD_BYTES);

`ifdef DU_RX_TIMEOUT_EN
    logic [31:0] idle_cycles;

    // Count silent cycles while a load is in progress; any byte restarts the count.
    always_ff @(posedge i_clock) begin
        if (i_reset || !in_load || i_uart_rx_done) begin
            idle_cycles <= '0;
        end else begin
            idle_cycles <= idle_cycles + 32'd1;
        end
    end

    assign timeout_hit = in_load && !i_uart_rx_done &&
                         (idle_cycles == 32'(TIMEOUT_CYCLES - 1));
`else
    // Without the counter the timeout length has no meaning; tie it off quietly.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and one-cycle-early pulse requests.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        load_begin = 1'b0;
        count_take = 1'b0;
        byte_take  = 1'b0;
        last_write = 1'b0;
        load_abort = 1'b0;
        start_nxt  = 1'b0;
        step_nxt   = 1'b0;
        error_nxt  = 1'b0;
        mode_nxt   = o_execution_mode;

        case (state)
            IDLE: begin
                if (i_uart_rx_done) begin
                    case (i_uart_rx_data)
                        CMD_LOAD: begin
                            load_begin = 1'b1;
                            next_state = LOAD_COUNT;
                        end
                        CMD_CONT, CMD_STEP: begin
                            if (!o_program_loaded) begin
                                error_nxt = 1'b1;
                            end else begin
                                start_nxt  = 1'b1;
                                mode_nxt   = (i_uart_rx_data == CMD_STEP);
                                next_state = (i_uart_rx_data == CMD_STEP) ? RUN_STEP : RUN_CONT;
                            end
                        end
                        default: error_nxt = 1'b1;
                    endcase
                end
            end
            LOAD_COUNT: begin
                if (i_uart_rx_done) begin
                    count_take = 1'b1;
                    next_state = (i_uart_rx_data == '0) ? IDLE : LOAD_BYTES;
                end
            end
            LOAD_BYTES: begin
                byte_take = i_uart_rx_done;
                if (o_instruction_write && (word_done == word_total - NB_BYTE'(1))) begin
                    last_write = 1'b1;
                    next_state = IDLE;
                end
            end
            RUN_CONT: begin
                if (i_halt) begin
                    next_state = WAIT_DUMP;
                end
            end
            RUN_STEP: begin
                // A halt seen together with a step request takes priority.
                if (i_halt) begin
                    next_state = WAIT_DUMP;
                end else if (i_uart_rx_done && (i_uart_rx_data == CMD_NEXT)) begin
                    step_nxt   = 1'b1;
                    next_state = WAIT_TX;
                end
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    next_state = i_halt ? IDLE : RUN_STEP;
                end
            end
            WAIT_DUMP: begin
                if (i_tx_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        if (timeout_hit && !last_write) begin
            load_abort = 1'b1;
            error_nxt  = 1'b1;
            byte_take  = 1'b0;
            next_state = IDLE;
        end
    end

    // Load datapath and registered output pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_instruction_data    <= '0;
            o_instruction_address <= '0;
            o_instruction_write   <= 1'b0;
            o_execution_mode      <= 1'b0;
            o_start               <= 1'b0;
            o_step                <= 1'b0;
            o_program_loaded      <= 1'b0;
            o_error               <= 1'b0;
            word_total            <= '0;
            word_done             <= '0;
            byte_idx              <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            o_start             <= start_nxt;
            o_step              <= step_nxt;
            o_error             <= error_nxt;
            o_execution_mode    <= mode_nxt;
            o_instruction_write <= byte_take && (byte_idx == NB_IDX'(BYTES_PER_WORD - 1));

            if (load_begin) begin
                o_instruction_address <= '0;
                word_done             <= '0;
                byte_idx              <= '0;
            end

            if (count_take) begin
                word_total <= i_uart_rx_data;
            end

            // A byte arriving during the write strobe shifts in after the
            // strobe cycle, so the word being written is still intact.
            if (byte_take) begin
                o_instruction_data <= {o_instruction_data[NB_DATA-NB_BYTE-1:0], i_uart_rx_data};
                byte_idx           <= (byte_idx == NB_IDX'(BYTES_PER_WORD - 1)) ? '0
                                                                               : byte_idx + NB_IDX'(1);
            end

            if (o_instruction_write) begin
                o_instruction_address <= o_instruction_address + NB_ADDR'(4);
                word_done             <= word_done + NB_BYTE'(1);
            end

            if (last_write) begin
                o_program_loaded <= 1'b1;
            end

            if (load_abort) begin
                o_instruction_address <= '0;
            end
        end
    end

endmodule
